// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer driven by a synchronized, edge-detected scaledclk tick.
// Optional build macro TIMER_AUTORELOAD_EN: reload from the last loaded value on expiry.
`timescale 1ns/1ps
module countdown_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scaledclk,
    input  logic       clear,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [7:0] min_in,
    input  logic [7:0] sec_in,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       done_pulse
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick;

    logic [1:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          pulse_q, pulse_d;
    logic [15:0]   dec_val;
    logic [15:0]   load_val;
`ifdef TIMER_AUTORELOAD_EN
    logic [15:0]   shadow_q, shadow_d;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    function automatic logic [15:0] bcd_clamp(input logic [7:0] m, input logic [7:0] s);
        return {clamp_digit(m[7:4], 4'd9), clamp_digit(m[3:0], 4'd9),
                clamp_digit(s[7:4], 4'd5), clamp_digit(s[3:0], 4'd9)};
    endfunction

    // Borrow ripples sec ones -> sec tens -> min ones -> min tens; 00:00 is a floor.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = v;
        if (v != 16'h0000) begin
            if (so != 4'd0) begin
                so = so - 4'd1;
            end else begin
                so = 4'd9;
                if (st != 4'd0) begin
                    st = st - 4'd1;
                end else begin
                    st = 4'd5;
                    if (mo != 4'd0) begin
                        mo = mo - 4'd1;
                    end else begin
                        mo = 4'd9;
                        mt = mt - 4'd1;
                    end
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // scaledclk is data: synchronize, then one tick per rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], scaledclk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick     = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign dec_val  = bcd_dec(cnt_q);
    assign load_val = bcd_clamp(min_in, sec_in);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        pulse_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
        shadow_d = shadow_q;
`endif
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = 16'h0000;
            presc_d = '0;
`ifdef TIMER_AUTORELOAD_EN
            shadow_d = 16'h0000;
`endif
        end else if (load && (state_q != S_RUN)) begin
            state_d = S_IDLE;
            cnt_d   = load_val;
`ifdef TIMER_AUTORELOAD_EN
            shadow_d = load_val;
`endif
        end else if (pause && (state_q == S_RUN)) begin
            state_d = S_PAUSE;
        end else if (start && ((state_q == S_IDLE) || (state_q == S_PAUSE) ||
                               ((state_q == S_DONE) && (cnt_q != 16'h0000)))) begin
            state_d = S_RUN;
            if (state_q != S_PAUSE) begin
                presc_d = '0;
            end
        end else if (state_q == S_RUN) begin
            // Reaching zero, or starting from zero, expires on this cycle.
            if ((cnt_q == 16'h0000) ||
                (tick && (presc_q == PRESC_MAX) && (dec_val == 16'h0000))) begin
                pulse_d = 1'b1;
                presc_d = '0;
`ifdef TIMER_AUTORELOAD_EN
                cnt_d   = shadow_q;
`else
                cnt_d   = 16'h0000;
                state_d = S_DONE;
`endif
            end else if (tick) begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    cnt_d   = dec_val;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'h0000;
            presc_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef TIMER_AUTORELOAD_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q <= 16'h0000;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign min_bcd    = cnt_q[15:8];
    assign sec_bcd    = cnt_q[7:0];
    assign running    = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign done_pulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed stimulus queues expected snapshots,
// a monitor process pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_countdown_timer;

`ifdef TIMER_AUTORELOAD_EN
    localparam int TD = 2;
`else
    localparam int TD = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scaledclk = 1'b0;
    logic       clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [7:0] min_in = 8'h00, sec_in = 8'h00;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, done, done_pulse;

    always #5 clock = ~clock;

    countdown_timer #(.SYNC_STAGES(2), .TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .scaledclk(scaledclk),
        .clear(clear), .load(load), .start(start), .pause(pause),
        .min_in(min_in), .sec_in(sec_in),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .running(running), .done(done), .done_pulse(done_pulse)
    );

    typedef struct {
        string      name;
        logic [7:0] m;
        logic [7:0] s;
        logic       run;
        logic       dn;
        int         pulses;
    } exp_t;

    exp_t exp_q[$];
    event push_ev;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pulse_cnt = 0;

    always @(negedge clock) begin
        if (done_pulse === 1'b1) pulse_cnt++;
    end

    // Monitor: compares every queued expectation against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(push_ev);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (min_bcd !== e.m || sec_bcd !== e.s || running !== e.run ||
                    done !== e.dn || pulse_cnt != e.pulses) begin
                    n_fail++;
                    $display("FAIL %s: got %h:%h run=%b done=%b pulses=%0d, want %h:%h run=%b done=%b pulses=%0d",
                             e.name, min_bcd, sec_bcd, running, done, pulse_cnt,
                             e.m, e.s, e.run, e.dn, e.pulses);
                end
            end
        end
    end

    task automatic expect_state(input string name, input logic [7:0] m, input logic [7:0] s,
                                input logic run, input logic dn, input int p);
        exp_t e;
        #1;
        e.name = name; e.m = m; e.s = s; e.run = run; e.dn = dn; e.pulses = p;
        exp_q.push_back(e);
        -> push_ev;
    endtask

    task automatic ctl(input logic c, input logic l, input logic st, input logic p,
                       input logic [7:0] m, input logic [7:0] s);
        @(negedge clock);
        clear = c; load = l; start = st; pause = p; min_in = m; sec_in = s;
        @(negedge clock);
        clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic tick(input int hi);
        @(negedge clock);
        scaledclk = 1'b1;
        repeat (hi) @(negedge clock);
        scaledclk = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        expect_state("reset", 8'h00, 8'h00, 0, 0, 0);

        ctl(0, 1, 0, 0, 8'h7A, 8'hFC);
        expect_state("clamp", 8'h79, 8'h59, 0, 0, 0);

`ifdef TIMER_AUTORELOAD_EN
        ctl(0, 1, 0, 0, 8'h00, 8'h01);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        expect_state("ar_start", 8'h00, 8'h01, 1, 0, 0);
        tick(4);
        expect_state("ar_tick1", 8'h00, 8'h01, 1, 0, 0);
        tick(2);
        expect_state("ar_tick2", 8'h00, 8'h01, 1, 0, 1);
        tick(6);
        expect_state("ar_tick3", 8'h00, 8'h01, 1, 0, 1);
        tick(1);
        expect_state("ar_tick4", 8'h00, 8'h01, 1, 0, 2);
        ctl(1, 0, 0, 0, 8'h00, 8'h00);
        expect_state("ar_clear", 8'h00, 8'h00, 0, 0, 2);
        tick(4);
        expect_state("ar_idle_tick", 8'h00, 8'h00, 0, 0, 2);
`else
        // Same-cycle clear+load+start: clear wins.
        ctl(1, 1, 1, 0, 8'h12, 8'h34);
        expect_state("clr_ld_st", 8'h00, 8'h00, 0, 0, 0);
        tick(4);
        expect_state("idle_tick", 8'h00, 8'h00, 0, 0, 0);

        ctl(0, 1, 0, 0, 8'h10, 8'h00);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        expect_state("run10", 8'h10, 8'h00, 1, 0, 0);
        @(negedge clock);
        scaledclk = 1'b1;
        @(negedge clock);
        expect_state("borrow_e1", 8'h10, 8'h00, 1, 0, 0);
        @(negedge clock);
        expect_state("borrow_e2", 8'h10, 8'h00, 1, 0, 0);
        @(negedge clock);
        expect_state("borrow_e3", 8'h09, 8'h59, 1, 0, 0);
        repeat (5) @(negedge clock);
        expect_state("long_high", 8'h09, 8'h59, 1, 0, 0);
        scaledclk = 1'b0;
        repeat (3) @(negedge clock);

        ctl(0, 1, 0, 0, 8'h00, 8'h30);
        expect_state("load_in_run", 8'h09, 8'h59, 1, 0, 0);
        ctl(0, 0, 0, 1, 8'h00, 8'h00);
        expect_state("paused", 8'h09, 8'h59, 0, 0, 0);
        ctl(0, 1, 0, 0, 8'h00, 8'h30);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        expect_state("run30", 8'h00, 8'h30, 1, 0, 0);
        ctl(0, 0, 0, 1, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) tick(3);
        expect_state("pause5", 8'h00, 8'h30, 0, 0, 0);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        tick(4);
        expect_state("resume29", 8'h00, 8'h29, 1, 0, 0);

        // Pause lands on the same edge that would apply the tick.
        @(negedge clock);
        scaledclk = 1'b1;
        @(negedge clock);
        @(negedge clock);
        pause = 1'b1;
        @(negedge clock);
        pause = 1'b0;
        expect_state("pause_tick", 8'h00, 8'h29, 0, 0, 0);
        repeat (3) @(negedge clock);
        scaledclk = 1'b0;
        repeat (3) @(negedge clock);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        expect_state("resumed", 8'h00, 8'h29, 1, 0, 0);

        ctl(0, 0, 0, 1, 8'h00, 8'h00);
        ctl(0, 1, 0, 0, 8'h00, 8'h37);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        expect_state("run37", 8'h00, 8'h37, 1, 0, 0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        scaledclk = 1'b1;
        expect_state("async_reset", 8'h00, 8'h00, 0, 0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        scaledclk = 1'b0;
        repeat (2) @(negedge clock);
        expect_state("post_reset", 8'h00, 8'h00, 0, 0, 0);

        ctl(0, 1, 0, 0, 8'h00, 8'h05);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        ctl(1, 0, 0, 0, 8'h00, 8'h00);
        expect_state("clear_run", 8'h00, 8'h00, 0, 0, 0);

        ctl(0, 1, 0, 0, 8'h00, 8'h02);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        tick(4);
        expect_state("exp_01", 8'h00, 8'h01, 1, 0, 0);
        tick(4);
        expect_state("exp_00", 8'h00, 8'h00, 0, 1, 1);
        tick(4);
        expect_state("exp_more", 8'h00, 8'h00, 0, 1, 1);
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        expect_state("start_done0", 8'h00, 8'h00, 0, 1, 1);
        ctl(1, 0, 0, 0, 8'h00, 8'h00);
        expect_state("clear_done", 8'h00, 8'h00, 0, 0, 1);

        // Start at 00:00: one RUN cycle, then DONE with a single strobe.
        ctl(0, 0, 1, 0, 8'h00, 8'h00);
        expect_state("start00_run", 8'h00, 8'h00, 1, 0, 1);
        @(negedge clock);
        expect_state("start00_done", 8'h00, 8'h00, 0, 1, 2);
        repeat (2) @(negedge clock);
        expect_state("pulse_once", 8'h00, 8'h00, 0, 1, 2);
`endif

        repeat (2) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Consumes the slow `scaledclk` output of the clock-scaler stage and runs an MM:SS BCD countdown in the 100 MHz `clock` domain. `scaledclk` is treated as data, never as a clock: it is synchronized and edge-detected into a one-cycle tick. Provides load/start/pause/clear control, running/done status and BCD digits for the seven-segment display stage downstream.

Parameters:
SYNC_STAGES, 2, flip-flops in the `scaledclk` synchronizer (min 2)
TICK_DIV, 1, ticks per one-second decrement (1 = one `scaledclk` rising edge per second)

Ports:
clock  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
scaledclk  in  1  divided clock from the scaler stage; sampled as data
clear  in  1  return to IDLE, zero the count
load  in  1  latch `min_in`/`sec_in` into the count
start  in  1  begin or resume counting
pause  in  1  suspend counting
min_in  in  8  BCD minutes {tens, ones}
sec_in  in  8  BCD seconds {tens, ones}
min_bcd  out  8  current minutes, BCD
sec_bcd  out  8  current seconds, BCD
running  out  1  high in RUN
done  out  1  high in DONE
done_pulse  out  1  one-cycle strobe on reaching 00:00

Behaviour:
- Reset (async): state IDLE; count, prescaler, synchronizer, all outputs 0.
- Tick generation:
  - `scaledclk` passes through SYNC_STAGES flops plus one history flop; `tick = sync_last & ~hist`.
  - With SYNC_STAGES=2, the count changes on the 3rd rising `clock` edge after `scaledclk` is first sampled high.
  - One tick per `scaledclk` rising edge, regardless of high time.
- Prescaler: 0..TICK_DIV-1; a decrement occurs when the prescaler wraps.
  - Cleared on start from IDLE/DONE.
  - Held in PAUSE.
- States: IDLE, RUN, PAUSE, DONE.
- Control priority, same cycle: clear > load > pause > start.
  - clear: any state -> IDLE; count = 00:00.
  - load: accepted in IDLE, PAUSE, DONE; ignored in RUN. Next state IDLE.
  - start: IDLE/PAUSE -> RUN; DONE -> RUN only if count != 00:00; ignored in RUN.
  - pause: RUN -> PAUSE. A tick in the same cycle is discarded.
- Load clamping: each ones digit >9 -> 9; seconds tens >5 -> 5; minutes tens >9 -> 9. Example: 0x7A -> 0x79, 0xFC -> 0x59.
- Decrement (RUN, prescaler wrap), BCD with borrow:
  - sec ones 0 -> 9, borrow to sec tens.
  - sec tens 0 -> 5, borrow to min ones.
  - min ones 0 -> 9, borrow to min tens.
  - Never decrements below 00:00.
- Expiry: when a decrement produces 00:00, next state DONE.
  - `done_pulse` high for exactly that one cycle.
  - `done` high while in DONE.
- Start at 00:00 from IDLE: RUN for one cycle, then DONE with `done_pulse`.
- Ticks in IDLE, PAUSE, DONE: no effect on the count.
- Outputs are registered. `running`/`done` follow state with zero added latency after the state register.

Optional Feature:
TIMER_AUTORELOAD_EN
- Defined: a shadow register holds the last loaded (clamped) value. On expiry the count reloads from it and stays in RUN; `done_pulse` fires every expiry; `done` stays 0. clear also zeroes the shadow.
- Undefined: no shadow register; expiry behaviour as in Behaviour.

Test Plan:
1. Reset mid-count: reset asserted while RUN at 00:37 -> all outputs 0 immediately (async), state IDLE, no tick honoured until after deassert.
2. Borrow chain: load 10:00, start, one `scaledclk` edge -> `min_bcd`=0x09, `sec_bcd`=0x59, exactly 3 `clock` edges after sampled rise.
3. Expiry: load 00:02, start, 2 ticks -> 00:00, `done`=1, `done_pulse` high 1 cycle, `running`=0; further ticks leave 00:00.
4. Pause: RUN at 00:30, pause, 5 ticks -> still 00:30; start, 1 tick -> 00:29. Pause coincident with tick -> no decrement.
5. Clamp/priority: load `min_in`=0x7A, `sec_in`=0xFC -> 79:59. Same-cycle clear+load+start -> IDLE, 00:00.
6. With TIMER_AUTORELOAD_EN, TICK_DIV=2: load 00:01, start, 4 ticks -> two `done_pulse`s, `running` stays 1, count returns to 00:01.
